pc_pipe_chain: RTL and testbench
================================

Name: pc_pipe_chain

Overview:
Parametrised program-counter pipeline for the RISC V core. It carries each fetched PC, with a valid bit, through DEPTH stage registers. It produces a registered link value (oldest stage + LINK_OFFSET) for the return-address/writeback stage. It adds stall, partial flush, a configurable post-flush hold window and a busy indication.

Parameters:
WIDTH, 32, PC width in bits
DEPTH, 2, number of PC stage registers (>=2); stage 0 youngest, stage DEPTH-1 oldest
FLUSH_STAGES, 2, youngest stages cleared on flush (1..DEPTH)
HOLD_CYCLES, 1, cycles the chain is frozen after a flush (0..15)
LINK_OFFSET, 4, constant added to oldest stage to form link_o

Ports:
clk  in  1  processor main clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold all registers this cycle
flush_i  in  1  discard younger stages (nop insertion)
pc_i  in  WIDTH  PC from fetch
valid_i  in  1  pc_i is a real instruction
stage_pc_o  out  DEPTH*WIDTH  stage i PC at bits [i*WIDTH +: WIDTH]
stage_valid_o  out  DEPTH  per-stage valid
link_o  out  WIDTH  registered oldest-stage PC + LINK_OFFSET
link_valid_o  out  1  valid accompanying link_o
busy_o  out  1  high while in HOLD (inputs ignored)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all stage PCs 0, all valids 0, link_o 0, link_valid_o 0, busy_o 0, state RUN, hold counter 0. Reset asserted mid-flush or mid-hold aborts immediately to these values.
- FSM states: RUN, HOLD. busy_o = (state==HOLD), registered.
- RUN, flush_i=1 (priority over stall_i):
  - link_o <= stage[DEPTH-1] + LINK_OFFSET; link_valid_o <= stage_valid[DEPTH-1].
  - Stages 0..FLUSH_STAGES-1 <= PC 0, valid 0.
  - Stages i >= FLUSH_STAGES <= stage[i-1] (PC and valid).
  - pc_i is dropped.
  - If HOLD_CYCLES>0: go to HOLD, counter <= HOLD_CYCLES-1. Otherwise stay in RUN.
- RUN, stall_i=1, flush_i=0: every register, including link_o, holds.
- RUN, idle (neither asserted):
  - stage[0] <= {pc_i, valid_i}; stage[i] <= stage[i-1].
  - link_o <= stage[DEPTH-1] + LINK_OFFSET; link_valid_o <= stage_valid[DEPTH-1].
- HOLD: all data registers hold. flush_i, stall_i and pc_i are ignored. Counter decrements; at 0 return to RUN. First capture happens on the edge after busy_o falls.
- Arithmetic: addition is modulo 2^WIDTH; no carry out. 0xFFFFFFFC+4 = 0.
- Latency: pc_i appears on stage 0 one edge after capture and on link_o DEPTH+1 edges after capture, absent stalls.

Optional Feature:
PC_PIPE_MISALIGN_CHECK_EN.
- Defined: extra output misalign_o (1 bit, reset 0).
  - Sticky-set on any RUN capture edge where valid_i=1 and pc_i[1:0]!=0.
  - Cleared only by rst_n.
  - PC is still captured unchanged.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - localparams PC_W=32 and PC_LINK_OFFSET=4.
  - State encoding: PCP_RUN=1'b0, PCP_HOLD=1'b1.
- One natural sub-module, pc_stage_reg: a WIDTH+1 register with async reset, enable and synchronous clear, instantiated DEPTH times via generate.
- Hold counter and FSM stay in the top.

Test Plan:
- Defaults, after reset, apply pc 0x100,0x104,0x108 on consecutive edges with valid_i=1 -> after 3rd edge stage0=0x108, stage1=0x104, link_o=0x104, link_valid_o=1.
- From stage0=0x108, stage1=0x104, pulse flush_i one cycle -> link_o=0x108, stages 0/valid 0, busy_o=1 for exactly 1 cycle. pc_i=0x10C during HOLD is not captured; pc_i=0x110 on the next edge lands in stage0.
- stall_i high 3 cycles with flush_i low -> stage_pc_o, link_o unchanged. stall_i and flush_i together -> flush behaviour.
- DEPTH=4, FLUSH_STAGES=2, HOLD_CYCLES=0, stages {0x10,0x0C,0x08,0x04} (young->old), flush -> stages {0,0,0x0C,0x08} with valids {0,0,1,1}, link_o=0x08, busy_o stays 0.
- Stage1=0xFFFFFFFC, advance -> link_o=0x00000000. Assert rst_n=0 asynchronously mid-HOLD -> all outputs 0 before next edge, state RUN.
- With PC_PIPE_MISALIGN_CHECK_EN: pc_i=0x102, valid_i=1 -> misalign_o=1 and stays 1. Same value with valid_i=0 -> misalign_o stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the PC pipeline chain.
package riscv_pkg;

  localparam int PC_W           = 32;
  localparam int PC_LINK_OFFSET = 4;

  typedef enum logic {
    PCP_RUN  = 1'b0,
    PCP_HOLD = 1'b1
  } pcp_state_e;

endpackage

// File: rtl/pc_stage_reg.sv
// One PC pipeline stage: PC plus valid bit, async reset, enable and
// synchronous clear (clear wins over enable).
module pc_stage_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH = PC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_pc,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_pc,
  output logic             q_valid
);

  // Stage storage: clear inserts a bubble, enable advances, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_pc    <= d_pc;
      q_valid <= d_valid;
    end else begin
      q_pc    <= q_pc;
      q_valid <= q_valid;
    end
  end

endmodule

// File: rtl/pc_pipe_chain.sv
// PC pipeline chain: DEPTH stage registers with stall, partial flush,
// post-flush hold window, busy flag and a registered link value.
// Optional macro PC_PIPE_MISALIGN_CHECK_EN adds a sticky misalign_o flag.
module pc_pipe_chain
  import riscv_pkg::*;
#(
  parameter int WIDTH        = PC_W,
  parameter int DEPTH        = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int LINK_OFFSET  = PC_LINK_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       pc_i,
  input  logic                   valid_i,
  output logic [DEPTH*WIDTH-1:0] stage_pc_o,
  output logic [DEPTH-1:0]       stage_valid_o,
  output logic [WIDTH-1:0]       link_o,
  output logic                   link_valid_o,
`ifdef PC_PIPE_MISALIGN_CHECK_EN
  output logic                   misalign_o,
`endif
  output logic                   busy_o
);

  pcp_state_e       state_r, state_nxt_s;
  logic [3:0]       hold_cnt_r, hold_cnt_nxt_s;
  logic             flush_act_s;
  logic             adv_s;
  logic [WIDTH-1:0] link_r;
  logic             link_valid_r;
  logic             busy_r;

  logic [WIDTH-1:0] stage_pc_s  [DEPTH];
  logic [WIDTH-1:0] d_pc_s      [DEPTH];
  logic [DEPTH-1:0] stage_valid_s;
  logic [DEPTH-1:0] d_valid_s;

  // Next-state logic: flush beats stall in RUN; HOLD counts down to RUN.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    flush_act_s    = 1'b0;
    adv_s          = 1'b0;
    case (state_r)
      PCP_RUN: begin
        if (flush_i) begin
          flush_act_s = 1'b1;
          if (HOLD_CYCLES > 0) begin
            state_nxt_s    = PCP_HOLD;
            hold_cnt_nxt_s = 4'(HOLD_CYCLES - 1);
          end else begin
            state_nxt_s = PCP_RUN;
          end
        end else if (!stall_i) begin
          adv_s = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      PCP_HOLD: begin
        if (hold_cnt_r == 4'd0) begin
          state_nxt_s = PCP_RUN;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s    = PCP_RUN;
        hold_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // FSM state, hold counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= PCP_RUN;
      hold_cnt_r <= 4'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      busy_r     <= (state_nxt_s == PCP_HOLD);
    end
  end

  // Stage chain: stage 0 takes fetch, others take their younger neighbour.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam bit CLR_EN = (i < FLUSH_STAGES);
    if (i == 0) begin : g_head
      assign d_pc_s[i]    = pc_i;
      assign d_valid_s[i] = valid_i;
    end else begin : g_body
      assign d_pc_s[i]    = stage_pc_s[i-1];
      assign d_valid_s[i] = stage_valid_s[i-1];
    end

    pc_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv_s | flush_act_s),
      .clr     (flush_act_s & CLR_EN),
      .d_pc    (d_pc_s[i]),
      .d_valid (d_valid_s[i]),
      .q_pc    (stage_pc_s[i]),
      .q_valid (stage_valid_s[i])
    );

    assign stage_pc_o[i*WIDTH +: WIDTH] = stage_pc_s[i];
  end

  // Link register: oldest stage plus offset, updated on advance or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_r       <= '0;
      link_valid_r <= 1'b0;
    end else if (adv_s || flush_act_s) begin
      link_r       <= stage_pc_s[DEPTH-1] + WIDTH'(LINK_OFFSET);
      link_valid_r <= stage_valid_s[DEPTH-1];
    end else begin
      link_r       <= link_r;
      link_valid_r <= link_valid_r;
    end
  end

`ifdef PC_PIPE_MISALIGN_CHECK_EN
  logic misalign_r;

  // Sticky flag for a valid fetch PC that is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (adv_s && valid_i && (pc_i[1:0] != 2'b00)) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign_o = misalign_r;
`endif

  assign stage_valid_o = stage_valid_s;
  assign link_o        = link_r;
  assign link_valid_o  = link_valid_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_pc_pipe_chain.sv
// Self-checking bench for pc_pipe_chain: two instances (DEPTH=2/HOLD=1 and
// DEPTH=4/HOLD=0) driven identically, checked against an array-based model.
module tb_pc_pipe_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        valid = 1'b0;

  logic [63:0]  a_pc;
  logic [1:0]   a_v;
  logic [31:0]  a_link;
  logic         a_lv;
  logic         a_busy;
  logic [127:0] b_pc;
  logic [3:0]   b_v;
  logic [31:0]  b_link;
  logic         b_lv;
  logic         b_busy;
`ifdef PC_PIPE_MISALIGN_CHECK_EN
  logic         a_mis;
  logic         b_mis;
`endif

  int total = 0;
  int fails = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  logic [31:0] m_pc   [2][4];
  logic        m_v    [2][4];
  logic [31:0] m_link [2];
  logic        m_lv   [2];
  int          m_hold [2];
  logic        m_mis  [2];

  always #5 clk = ~clk;

  pc_pipe_chain #(.WIDTH(32), .DEPTH(2), .FLUSH_STAGES(2), .HOLD_CYCLES(1), .LINK_OFFSET(4)) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .pc_i          (pc_in),
    .valid_i       (valid),
    .stage_pc_o    (a_pc),
    .stage_valid_o (a_v),
    .link_o        (a_link),
    .link_valid_o  (a_lv),
`ifdef PC_PIPE_MISALIGN_CHECK_EN
    .misalign_o    (a_mis),
`endif
    .busy_o        (a_busy)
  );

  pc_pipe_chain #(.WIDTH(32), .DEPTH(4), .FLUSH_STAGES(2), .HOLD_CYCLES(0), .LINK_OFFSET(4)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .pc_i          (pc_in),
    .valid_i       (valid),
    .stage_pc_o    (b_pc),
    .stage_valid_o (b_v),
    .link_o        (b_link),
    .link_valid_o  (b_lv),
`ifdef PC_PIPE_MISALIGN_CHECK_EN
    .misalign_o    (b_mis),
`endif
    .busy_o        (b_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_pc[k][i] = 32'd0;
        m_v[k][i]  = 1'b0;
      end
      m_link[k] = 32'd0;
      m_lv[k]   = 1'b0;
      m_hold[k] = 0;
      m_mis[k]  = 1'b0;
    end
  endtask

  // One clock edge of the pipeline behaviour for instance k.
  task automatic model_edge(input int k, input int depth, input int fs, input int hc);
    if (m_hold[k] > 0) begin
      m_hold[k]--;
    end else if (flush) begin
      m_link[k] = m_pc[k][depth-1] + 32'd4;
      m_lv[k]   = m_v[k][depth-1];
      for (int i = depth - 1; i >= 0; i--) begin
        if (i < fs) begin
          m_pc[k][i] = 32'd0;
          m_v[k][i]  = 1'b0;
        end else begin
          m_pc[k][i] = m_pc[k][i-1];
          m_v[k][i]  = m_v[k][i-1];
        end
      end
      m_hold[k] = hc;
    end else if (!stall) begin
      m_link[k] = m_pc[k][depth-1] + 32'd4;
      m_lv[k]   = m_v[k][depth-1];
      for (int i = depth - 1; i > 0; i--) begin
        m_pc[k][i] = m_pc[k][i-1];
        m_v[k][i]  = m_v[k][i-1];
      end
      m_pc[k][0] = pc_in;
      m_v[k][0]  = valid;
      if (valid && (pc_in % 4 != 0)) m_mis[k] = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [63:0]  ea;
    logic [127:0] eb;
    logic [1:0]   eva;
    logic [3:0]   evb;
    for (int i = 0; i < 2; i++) begin
      ea[i*32 +: 32] = m_pc[0][i];
      eva[i] = m_v[0][i];
    end
    for (int i = 0; i < 4; i++) begin
      eb[i*32 +: 32] = m_pc[1][i];
      evb[i] = m_v[1][i];
    end
    check({tag, ".a_pc"},   128'(a_pc),   128'(ea));
    check({tag, ".a_v"},    128'(a_v),    128'(eva));
    check({tag, ".a_link"}, 128'(a_link), 128'(m_link[0]));
    check({tag, ".a_lv"},   128'(a_lv),   128'(m_lv[0]));
    check({tag, ".a_busy"}, 128'(a_busy), 128'(m_hold[0] > 0));
    check({tag, ".b_pc"},   b_pc,         eb);
    check({tag, ".b_v"},    128'(b_v),    128'(evb));
    check({tag, ".b_link"}, 128'(b_link), 128'(m_link[1]));
    check({tag, ".b_lv"},   128'(b_lv),   128'(m_lv[1]));
    check({tag, ".b_busy"}, 128'(b_busy), 128'(m_hold[1] > 0));
`ifdef PC_PIPE_MISALIGN_CHECK_EN
    check({tag, ".a_mis"},  128'(a_mis),  128'(m_mis[0]));
    check({tag, ".b_mis"},  128'(b_mis),  128'(m_mis[1]));
`endif
  endtask

  task automatic step(input string tag, input logic st, input logic fl,
                      input logic [31:0] pc, input logic v);
    stall = st;
    flush = fl;
    pc_in = pc;
    valid = v;
    @(posedge clk);
    model_edge(0, 2, 2, 1);
    model_edge(1, 4, 2, 0);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fill.
    step("fill0", 1'b0, 1'b0, 32'h100, 1'b1);
    step("fill1", 1'b0, 1'b0, 32'h104, 1'b1);
    step("fill2", 1'b0, 1'b0, 32'h108, 1'b1);
    check("fill.stage0", 128'(a_pc[31:0]),  128'(32'h108));
    check("fill.stage1", 128'(a_pc[63:32]), 128'(32'h104));
    check("fill.link",   128'(a_link),      128'(32'h104));
    check("fill.lv",     128'(a_lv),        128'(1'b1));

    // Flush with one-cycle hold window on A.
    step("flush", 1'b0, 1'b1, 32'h200, 1'b1);
    check("flush.link", 128'(a_link), 128'(32'h108));
    check("flush.busy", 128'(a_busy), 128'(1'b1));
    check("flush.v",    128'(a_v),    128'(2'b00));
    step("hold", 1'b0, 1'b0, 32'h10C, 1'b1);
    check("hold.busy", 128'(a_busy), 128'(1'b0));
    check("hold.nocap", 128'(a_pc[31:0]), 128'(32'h0));
    step("post", 1'b0, 1'b0, 32'h110, 1'b1);
    check("post.stage0", 128'(a_pc[31:0]), 128'(32'h110));

    // Stall three cycles, then stall together with flush.
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h300, 1'b1);
    step("stallflush", 1'b1, 1'b1, 32'h304, 1'b1);
    step("afterflush", 1'b0, 1'b0, 32'h0, 1'b0);

    // Deep instance partial flush.
    step("deep0", 1'b0, 1'b0, 32'h04, 1'b1);
    step("deep1", 1'b0, 1'b0, 32'h08, 1'b1);
    step("deep2", 1'b0, 1'b0, 32'h0C, 1'b1);
    step("deep3", 1'b0, 1'b0, 32'h10, 1'b1);
    step("deepfl", 1'b0, 1'b1, 32'h14, 1'b1);
    check("deep.pc",   b_pc, {32'h08, 32'h0C, 32'h0, 32'h0});
    check("deep.v",    128'(b_v), 128'(4'b1100));
    check("deep.link", 128'(b_link), 128'(32'h08));
    check("deep.busy", 128'(b_busy), 128'(1'b0));
    step("deepidle", 1'b0, 1'b0, 32'h0, 1'b0);

    // Link wrap-around.
    step("wrap0", 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1);
    step("wrap1", 1'b0, 1'b0, 32'h20, 1'b1);
    step("wrap2", 1'b0, 1'b0, 32'h24, 1'b1);
    check("wrap.link", 128'(a_link), 128'(32'h0));

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] rpc;
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           rpc, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of HOLD.
    step("prerst", 1'b0, 1'b0, 32'h400, 1'b1);
    step("rstflush", 1'b0, 1'b1, 32'h404, 1'b1);
    check("rst.inhold", 128'(a_busy), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst.run", 1'b0, 1'b0, 32'h500, 1'b1);
    check("rst.cap", 128'(a_pc[31:0]), 128'(32'h500));

    // Misalign indication (instances without the option just track the model).
    step("mis.inv", 1'b0, 1'b0, 32'h102, 1'b0);
    step("mis.val", 1'b0, 1'b0, 32'h102, 1'b1);
    step("mis.stick", 1'b0, 1'b0, 32'h104, 1'b1);
`ifdef PC_PIPE_MISALIGN_CHECK_EN
    check("mis.a", 128'(a_mis), 128'(1'b1));
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
